// File: rtl/pipeline_scoreboard_pkg.sv
// Shared definitions for the decode-stage interlock: MIPS opcode values,
// default result latencies and the decode outcome encoding.
package pipeline_scoreboard_pkg;

   localparam logic [5:0] OP_RTYPE     = 6'h00;
   localparam logic [5:0] OP_J         = 6'h02;
   localparam logic [5:0] OP_JAL       = 6'h03;
   localparam logic [5:0] OP_BEQ       = 6'h04;
   localparam logic [5:0] OP_BNE       = 6'h05;
   localparam logic [5:0] OP_IARITH_LO = 6'h08;
   localparam logic [5:0] OP_IARITH_HI = 6'h0F;
   localparam logic [5:0] OP_LW        = 6'h23;
   localparam logic [5:0] OP_SW        = 6'h2B;

   localparam int DEFAULT_ALU_LAT  = 3;
   localparam int DEFAULT_LOAD_LAT = 4;
   localparam int DEFAULT_CNT_W    = 3;

   localparam logic [4:0] REG_RA = 5'd31;

   // What the decode stage does with the instruction it holds this cycle
   typedef enum logic [1:0] {
      DEC_IDLE,
      DEC_ISSUE,
      DEC_STALL,
      DEC_FLUSH
   } decode_action_e;

endpackage

// File: rtl/pipeline_scoreboard_decode.sv
// Register-usage decoder: which source registers an instruction reads and
// which register (if any) it writes. $0 is never reported as used or written.
module pipeline_scoreboard_decode
   import pipeline_scoreboard_pkg::*;
(
   input  logic [31:0] instr,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic        use_rs,
   output logic        use_rt,
   output logic [4:0]  dest,
   output logic        has_dest,
   output logic        is_load
);

   logic [5:0] opcode;
   logic       rs_read;
   logic       rt_read;
   logic       writes;

   assign opcode = instr[31:26];
   assign rs     = instr[25:21];
   assign rt     = instr[20:16];

   // Classify the opcode into register reads/writes; all-zero word is a nop
   always_comb begin
      rs_read = 1'b0;
      rt_read = 1'b0;
      writes  = 1'b0;
      dest    = 5'd0;
      is_load = 1'b0;
      if (instr != 32'd0) begin
         case (opcode)
            OP_RTYPE: begin
               rs_read = 1'b1;
               rt_read = 1'b1;
               writes  = 1'b1;
               dest    = instr[15:11];
            end
            OP_LW: begin
               rs_read = 1'b1;
               writes  = 1'b1;
               dest    = instr[20:16];
               is_load = 1'b1;
            end
            OP_SW, OP_BEQ, OP_BNE: begin
               rs_read = 1'b1;
               rt_read = 1'b1;
            end
            OP_JAL: begin
               writes = 1'b1;
               dest   = REG_RA;
            end
            default: begin
               if (opcode >= OP_IARITH_LO && opcode <= OP_IARITH_HI) begin
                  rs_read = 1'b1;
                  writes  = 1'b1;
                  dest    = instr[20:16];
               end
            end
         endcase
      end
   end

   assign use_rs   = rs_read && (rs != 5'd0);
   assign use_rt   = rt_read && (rt != 5'd0);
   assign has_dest = writes && (dest != 5'd0);

endmodule

// File: rtl/pipeline_scoreboard.sv
// Decode-stage interlock: per-register countdown timers mark results still in
// flight; decode stalls (PC held, bubble injected) while it reads one of them.
// A timer is loaded with LAT-1 so a producer issued at cycle t is readable at
// t+LAT, giving LAT-1 stall cycles for a back-to-back dependent instruction.
module pipeline_scoreboard
   import pipeline_scoreboard_pkg::*;
#(
   parameter int ALU_LAT  = DEFAULT_ALU_LAT,
   parameter int LOAD_LAT = DEFAULT_LOAD_LAT,
   parameter int CNT_W    = DEFAULT_CNT_W
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [31:0] id_instr,
   input  logic        flush,
   output logic        pc_write,
   output logic        ctrl_zero,
   output logic        issue,
   output logic [31:0] busy_mask,
   output logic [15:0] stall_cycles
);

   localparam logic [CNT_W-1:0] ALU_RELOAD  = CNT_W'(ALU_LAT - 1);
   localparam logic [CNT_W-1:0] LOAD_RELOAD = CNT_W'(LOAD_LAT - 1);

   logic [CNT_W-1:0] cnt [32];
   logic [4:0]       rs;
   logic [4:0]       rt;
   logic [4:0]       dest;
   logic             use_rs;
   logic             use_rt;
   logic             has_dest;
   logic             is_load;
   logic             hazard;
   decode_action_e   action;

   pipeline_scoreboard_decode u_decode (
      .instr    (id_instr),
      .rs       (rs),
      .rt       (rt),
      .use_rs   (use_rs),
      .use_rt   (use_rt),
      .dest     (dest),
      .has_dest (has_dest),
      .is_load  (is_load)
   );

   // A register is pending while its timer is non-zero; $0 is never pending
   always_comb begin
      busy_mask = 32'd0;
      for (int r = 1; r < 32; r++) begin
         busy_mask[r] = (cnt[r] != '0);
      end
   end

   assign hazard = id_valid && !flush &&
                   ((use_rs && busy_mask[rs]) || (use_rt && busy_mask[rt]));

   // Pick the decode outcome: flush beats stall beats issue
   always_comb begin
      action = DEC_IDLE;
      if (flush) begin
         action = DEC_FLUSH;
      end else if (hazard) begin
         action = DEC_STALL;
      end else if (id_valid) begin
         action = DEC_ISSUE;
      end
   end

   assign issue     = rst_n && (action == DEC_ISSUE);
   assign pc_write  = rst_n && (action != DEC_STALL);
   assign ctrl_zero = !issue;

   // Timers: an issue writing r restarts its timer, otherwise count down to 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < 32; r++) begin
            cnt[r] <= '0;
         end
      end else begin
         for (int r = 0; r < 32; r++) begin
            if (issue && has_dest && (dest == 5'(r))) begin
               cnt[r] <= is_load ? LOAD_RELOAD : ALU_RELOAD;
            end else if (cnt[r] != '0) begin
               cnt[r] <= cnt[r] - 1'b1;
            end
         end
      end
   end

   // Saturating count of cycles lost to data hazards
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= 16'd0;
      end else if (hazard && (stall_cycles != 16'hFFFF)) begin
         stall_cycles <= stall_cycles + 16'd1;
      end
   end

endmodule
